instr_encoder_loader: RTL and testbench

//  Assembles RV32I instruction words (R-type, LOAD, STORE, BRANCH: the four classes the single-cycle ControlUnit decodes)

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/rv_instr_encoder.sv | 35 +++
 rtl/instr_encoder_loader.sv | 120 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Opcode constants, instruction class codes and loader FSM states shared by
// the instruction encoder and the loader top.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] CLS_R      = 2'b00;
  localparam logic [1:0] CLS_LOAD   = 2'b01;
  localparam logic [1:0] CLS_STORE  = 2'b10;
  localparam logic [1:0] CLS_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational RV32I encoder for the R/LOAD/STORE/BRANCH classes; also flags
// a branch offset that is not 2-byte aligned (bit 0 is dropped from the word).
module rv_instr_encoder
  import riscv_pkg::*;
(
  input  logic [1:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic        misalign
);

  always_comb begin
    word     = '0;
    misalign = 1'b0;
    case (cls)
      CLS_R:
        word = {(funct7b5 ? F7_ALT : F7_BASE), rs2, rs1, funct3, rd, OP_RTYPE};
      CLS_LOAD:
        word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
      CLS_STORE:
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
      default: begin
        // B-type scatters the offset; imm[0] has no slot in the word
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        misalign = imm[0];
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Loader session FSM: accepts field-level requests, encodes them and writes
// the words sequentially into instruction memory from address 0.
module instr_encoder_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic              InValid,
  output logic              InReady,
  input  logic [1:0]        InClass,
  input  logic [2:0]        InFunct3,
  input  logic              InFunct7b5,
  input  logic [4:0]        InRd,
  input  logic [4:0]        InRs1,
  input  logic [4:0]        InRs2,
  input  logic [12:0]       InImm,
  input  logic              InLast,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWdata,
  output logic [ADDR_W:0]   Count,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_W:0]   COUNT_ONE = 1;

  state_t      state;
  state_t      state_next;
  logic        last_held;
  logic [31:0] enc_word;
  logic        enc_misalign;
  logic        at_top;

  rv_instr_encoder u_enc (
    .cls      (InClass),
    .funct3   (InFunct3),
    .funct7b5 (InFunct7b5),
    .rd       (InRd),
    .rs1      (InRs1),
    .rs2      (InRs2),
    .imm      (InImm),
    .word     (enc_word),
    .misalign (enc_misalign)
  );

  // Current write targets the last memory word
  assign at_top = &MemAddr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      MemAddr   <= '0;
      MemWdata  <= '0;
      Count     <= '0;
      Err       <= 1'b0;
      last_held <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            MemAddr <= '0;
            Count   <= '0;
            Err     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (InValid) begin
            MemWdata  <= enc_word;
            last_held <= InLast;
            if (enc_misalign) Err <= 1'b1;
          end
        end
        default: begin
          Count <= Count + COUNT_ONE;
          // No wrap at the top: address stays put and a missing InLast is an overflow
          if (at_top) begin
            if (!last_held) Err <= 1'b1;
          end else begin
            MemAddr <= MemAddr + ADDR_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    InReady    = 1'b0;
    MemWe      = 1'b0;
    Busy       = 1'b0;
    Done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (InValid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        MemWe      = 1'b1;
        Busy       = 1'b1;
        state_next = (last_held || at_top) ? ST_DONE : ST_LOAD;
      end
      default: begin
        Done = 1'b1;
        if (Start) state_next = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed and randomized bench for instr_encoder_loader: a full-size instance
// and a 4-word instance share request inputs but have separate Start lines.
module tb_instr_encoder_loader;

  typedef struct {
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_class = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_f7b5 = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [12:0] in_imm = '0;
  logic        in_last = 1'b0;

  logic        rdy_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  count_a;
  logic        rdy_b, we_b, busy_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] wr_addr_a[$], wr_data_a[$], wr_addr_b[$], wr_data_b[$];
  int          wr_cyc_a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_loader #(.ADDR_W(8)) dut_a (
    .clk(clk), .reset(reset), .Start(start_a), .InValid(in_valid), .InReady(rdy_a),
    .InClass(in_class), .InFunct3(in_funct3), .InFunct7b5(in_f7b5), .InRd(in_rd),
    .InRs1(in_rs1), .InRs2(in_rs2), .InImm(in_imm), .InLast(in_last),
    .MemWe(we_a), .MemAddr(addr_a), .MemWdata(wdata_a), .Count(count_a),
    .Busy(busy_a), .Done(done_a), .Err(err_a)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .Start(start_b), .InValid(in_valid), .InReady(rdy_b),
    .InClass(in_class), .InFunct3(in_funct3), .InFunct7b5(in_f7b5), .InRd(in_rd),
    .InRs1(in_rs1), .InRs2(in_rs2), .InImm(in_imm), .InLast(in_last),
    .MemWe(we_b), .MemAddr(addr_b), .MemWdata(wdata_b), .Count(count_b),
    .Busy(busy_b), .Done(done_b), .Err(err_b)
  );

  // Memory-side monitor: every write strobe is logged with its address/data
  always @(negedge clk) begin
    if (we_a) begin
      wr_addr_a.push_back(32'(addr_a));
      wr_data_a.push_back(wdata_a);
      wr_cyc_a.push_back(cyc);
    end
    if (we_b) begin
      wr_addr_b.push_back(32'(addr_b));
      wr_data_b.push_back(wdata_b);
    end
  end

  // Reference encoder built from the field placement rules with shifts/masks
  function automatic logic [31:0] model_word(input req_t r);
    logic [31:0] im, w, common;
    im     = 32'(r.imm);
    common = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    case (r.cls)
      2'd0: w = (r.f7b5 ? 32'h4000_0000 : 32'h0) | (32'(r.rs2) << 20) | common
                | (32'(r.rd) << 7) | 32'h33;
      2'd1: w = ((im & 32'hFFF) << 20) | common | (32'(r.rd) << 7) | 32'h03;
      2'd2: w = (((im >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | common
                | ((im & 32'h1F) << 7) | 32'h23;
      default: begin
        im = im & 32'h1FFE;
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r.rs2) << 20)
            | common | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | 32'h63;
      end
    endcase
    return w;
  endfunction

  function automatic req_t mk(input int cls, input int f3, input int f7b5, input int rd,
                              input int rs1, input int rs2, input int imm);
    req_t r;
    r.cls = 2'(cls); r.f3 = 3'(f3); r.f7b5 = 1'(f7b5);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = 13'(imm);
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk($urandom_range(3), $urandom_range(7), $urandom_range(1), $urandom_range(31),
              $urandom_range(31), $urandom_range(31), $urandom_range(13'h1FFF));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit use_b);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Presents one request and waits (bounded) for the handshake edge
  task automatic send(input req_t r, input logic last, input int gap, input bit use_b,
                      output bit ok);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_class = r.cls; in_funct3 = r.f3; in_f7b5 = r.f7b5; in_rd = r.rd;
    in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm; in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (use_b ? rdy_b : rdy_a) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input bit use_b, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (use_b ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check({tag, "_done"}, 64'(seen), 64'd1);
  endtask

  // Full session on dut_a: all requests, last flagged on the final one, then compare
  task automatic session_a(input req_t reqs[$], input int max_gap, input string tag);
    bit ok;
    bit exp_err = 1'b0;
    wr_addr_a.delete(); wr_data_a.delete(); wr_cyc_a.delete();
    pulse_start(1'b0);
    foreach (reqs[i]) begin
      send(reqs[i], (i == reqs.size() - 1), $urandom_range(max_gap), 1'b0, ok);
      check($sformatf("%s_accept%0d", tag, i), 64'(ok), 64'd1);
      if (reqs[i].cls == 2'd3 && reqs[i].imm[0]) exp_err = 1'b1;
    end
    wait_done(1'b0, tag);
    check({tag, "_nwrites"}, 64'(wr_data_a.size()), 64'(reqs.size()));
    foreach (reqs[i]) begin
      if (i < wr_data_a.size()) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_a[i]), 64'(i));
        check($sformatf("%s_word%0d", tag, i), 64'(wr_data_a[i]), 64'(model_word(reqs[i])));
      end
    end
    check({tag, "_count"}, 64'(count_a), 64'(reqs.size()));
    check({tag, "_err"}, 64'(err_a), 64'(exp_err));
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_addr_next"}, 64'(addr_a), 64'(reqs.size()));
  endtask

  initial begin
    req_t q[$];
    bit   ok;

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(rdy_a), 64'd0);
    check("rst_we", 64'(we_a), 64'd0);
    check("rst_addr", 64'(addr_a), 64'd0);
    check("rst_wdata", 64'(wdata_a), 64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_flags", {61'd0, busy_a, done_a, err_a}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(rdy_a), 64'd0);

    // add x3,x1,x2 as a single-word session
    q = '{mk(0, 0, 0, 3, 1, 2, 0)};
    session_a(q, 0, "add");
    check("add_const", 64'(wr_data_a[0]), 64'h0020_81B3);
    check("add_done_flag", 64'(done_a), 64'd1);

    // sub / lw / sw / beq sequence against fixed encodings
    q = '{mk(0, 0, 1, 5, 6, 7, 0), mk(1, 2, 0, 4, 2, 0, 8), mk(2, 2, 0, 0, 2, 5, 12),
          mk(3, 0, 0, 0, 1, 2, 13'h1FF8)};
    session_a(q, 2, "seq");
    check("seq_c0", 64'(wr_data_a[0]), 64'h4073_02B3);
    check("seq_c1", 64'(wr_data_a[1]), 64'h0081_2203);
    check("seq_c2", 64'(wr_data_a[2]), 64'h0051_2623);
    check("seq_c3", 64'(wr_data_a[3]), 64'hFE20_8CE3);

    // InValid held high throughout: writes must come exactly every 2 cycles
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(rand_req());
    session_a(q, 0, "cont");
    for (int i = 1; i < wr_cyc_a.size(); i++)
      check($sformatf("cont_spacing%0d", i), 64'(wr_cyc_a[i] - wr_cyc_a[i-1]), 64'd2);

    // Misaligned branch offset: sticky error, word uses imm=8, session continues
    q = '{mk(3, 1, 0, 0, 4, 9, 13'h0009), mk(0, 0, 0, 3, 1, 2, 0)};
    session_a(q, 1, "mis");
    check("mis_word_imm8", 64'(wr_data_a[0]), 64'(model_word(mk(3, 1, 0, 0, 4, 9, 8))));
    check("mis_count", 64'(count_a), 64'd2);
    pulse_start(1'b0);
    check("mis_err_cleared", 64'(err_a), 64'd0);
    check("mis_restart_busy", {62'd0, busy_a, done_a}, 64'd2);

    // Reset while the write strobe is high
    send(rand_req(), 1'b0, 0, 1'b0, ok);
    in_valid = 1'b0;
    check("rw_accept", 64'(ok), 64'd1);
    check("rw_we_before", 64'(we_a), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rw_outputs", {rdy_a, we_a, busy_a, done_a, err_a, addr_a, count_a}, 64'd0);
    check("rw_wdata", 64'(wdata_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rw_idle", {62'd0, busy_a, rdy_a}, 64'd0);

    // Start while busy must not restart the address
    wr_addr_a.delete(); wr_data_a.delete(); wr_cyc_a.delete();
    pulse_start(1'b0);
    send(mk(0, 0, 0, 1, 2, 3, 0), 1'b0, 0, 1'b0, ok);
    send(mk(0, 0, 0, 4, 5, 6, 0), 1'b0, 0, 1'b0, ok);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("ign_addr", 64'(addr_a), 64'd2);
    check("ign_count", 64'(count_a), 64'd2);
    send(mk(1, 2, 0, 7, 8, 0, 100), 1'b1, 0, 1'b0, ok);
    wait_done(1'b0, "ign");
    check("ign_last_addr", 64'(wr_addr_a[wr_addr_a.size()-1]), 64'd2);
    check("ign_count_end", 64'(count_a), 64'd3);

    // 4-word memory, 5 requests without InLast: overflow after 4 writes
    q.delete();
    for (int i = 0; i < 5; i++) q.push_back(mk(1, i, 0, i + 1, 2, 0, i * 4));
    wr_addr_b.delete(); wr_data_b.delete();
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) begin
      send(q[i], 1'b0, 0, 1'b1, ok);
      check($sformatf("full_accept%0d", i), 64'(ok), 64'(i < 4));
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("full_nwrites", 64'(wr_data_b.size()), 64'd4);
    for (int i = 0; i < 4 && i < wr_data_b.size(); i++) begin
      check($sformatf("full_addr%0d", i), 64'(wr_addr_b[i]), 64'(i));
      check($sformatf("full_word%0d", i), 64'(wr_data_b[i]), 64'(model_word(q[i])));
    end
    check("full_err", 64'(err_b), 64'd1);
    check("full_count", 64'(count_b), 64'd4);
    check("full_done", 64'(done_b), 64'd1);

    // 4-word memory filled exactly with InLast on the top word: no overflow
    wr_addr_b.delete(); wr_data_b.delete();
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) send(q[i], (i == 3), 1, 1'b1, ok);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("exact_nwrites", 64'(wr_data_b.size()), 64'd4);
    check("exact_err", 64'(err_b), 64'd0);
    check("exact_done_count", {60'd0, done_b, count_b}, {60'd0, 1'b1, 3'd4});

    // Randomized sessions of random length and gaps
    for (int s = 0; s < 8; s++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) q.push_back(rand_req());
      session_a(q, 3, $sformatf("rnd%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
